// File: rtl/led_pwm_driver.sv
`timescale 1ns/1ps
// led_pwm_driver: gates the PIO's 8-bit LED mask with an 8-bit PWM brightness
// and an optional blink, controlled through a small Avalon-MM register slave.
// Optional build macro LED_PWM_ACTIVE_LOW_EN inverts the pin drive (reset FF)
// for boards whose LEDs light on a low level; readdata is unaffected.
module led_pwm_driver #(
    parameter int PRESCALE_DIV = 196,
    parameter int BLINK_W      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  led_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  led_out
);

    localparam int PS_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

    logic [PS_W-1:0]    ps_cnt;
    logic               tick;
    logic               frame_end;
    logic [7:0]         pwm_cnt;
    logic               enable;
    logic               blink_en;
    logic [7:0]         duty_reg;
    logic [7:0]         duty_act;
    logic [BLINK_W-1:0] blink_period;
    logic [BLINK_W-1:0] frame_cnt;
    logic               blink_phase;
    logic [7:0]         led_in_q;
    logic               wr_en;
    logic               pwm_on;
    logic               led_gate;
    logic [7:0]         led_drive;
    logic               unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign tick         = (ps_cnt == PS_LAST);
    assign frame_end    = tick & (pwm_cnt == 8'hFF);
    assign pwm_on       = (duty_act == 8'hFF) | (pwm_cnt < duty_act);
    assign led_gate     = enable & pwm_on & (blink_phase | ~blink_en);
    assign led_drive    = led_in_q & {8{led_gate}};
    assign unused_wdata = &{1'b0, writedata[31:BLINK_W]};

    // Prescaler: one-cycle tick every PRESCALE_DIV clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ps_cnt <= '0;
        else if (tick)
            ps_cnt <= '0;
        else
            ps_cnt <= ps_cnt + PS_W'(1);
    end

    // PWM step counter, wraps naturally at 255
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pwm_cnt <= 8'h00;
        else if (tick)
            pwm_cnt <= pwm_cnt + 8'd1;
    end

    // Software-visible control registers; STATUS (addr 3) is read-only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable       <= 1'b1;
            blink_en     <= 1'b0;
            duty_reg     <= 8'hFF;
            blink_period <= '0;
        end else if (wr_en) begin
            case (address)
                2'd0: {blink_en, enable} <= writedata[1:0];
                2'd1: duty_reg           <= writedata[7:0];
                2'd2: blink_period       <= writedata[BLINK_W-1:0];
                default: ;
            endcase
        end
    end

    // Active duty only changes at a frame boundary so a frame is never cut short
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            duty_act <= 8'hFF;
        else if (frame_end)
            duty_act <= duty_reg;
    end

    // Blink: toggle phase every blink_period frames; a period write restarts the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wr_en && (address == 2'd2)) begin
            frame_cnt <= '0;
        end else if (blink_period == '0) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_end) begin
            if (frame_cnt == blink_period - BLINK_W'(1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + BLINK_W'(1);
            end
        end
    end

    // Input capture then gated output flop: two clocks from led_in to the pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_in_q <= 8'h00;
`ifdef LED_PWM_ACTIVE_LOW_EN
            led_out  <= 8'hFF;
`else
            led_out  <= 8'h00;
`endif
        end else begin
            led_in_q <= led_in;
`ifdef LED_PWM_ACTIVE_LOW_EN
            led_out  <= ~led_drive;
`else
            led_out  <= led_drive;
`endif
        end
    end

    // Combinational register read, zero-extended
    always_comb begin
        readdata = 32'h0;
        case (address)
            2'd0: readdata = {30'h0, blink_en, enable};
            2'd1: readdata = {24'h0, duty_reg};
            2'd2: readdata = 32'(blink_period);
            2'd3: readdata = {23'h0, blink_phase, pwm_cnt};
            default: readdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
`timescale 1ns/1ps
// Randomised bench for led_pwm_driver with an arithmetic reference model
// (PWM position and blink phase derived from elapsed edge/frame counts).
module tb_led_pwm_driver;

    localparam int DIV   = 2;
    localparam int BW    = 16;
    localparam int FRAME = 256 * DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  led_in = 8'h00;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [7:0]  led_out;

    int vectors = 0;
    int miscompares = 0;

    led_pwm_driver #(.PRESCALE_DIV(DIV), .BLINK_W(BW)) dut (
        .clk(clk), .reset_n(reset_n), .led_in(led_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .led_out(led_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef LED_PWM_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned  n = 0;          // clock edges since reset release
    logic         m_en = 1'b1;
    logic         m_ben = 1'b0;
    logic [7:0]   m_duty = 8'hFF;
    logic [7:0]   m_act = 8'hFF;
    logic [BW-1:0] m_per = '0;
    logic         m_anchor = 1'b1; // blink phase at the last count restart
    int unsigned  m_fsa = 0;       // frame ends since that restart
    logic [7:0]   m_inq = 8'h00;
    logic [7:0]   m_out = pol(8'h00);

    function automatic logic [7:0] m_pwm();
        return 8'((n / DIV) % 256);
    endfunction

    function automatic logic m_phase();
        if (m_per == '0) return m_anchor;
        return m_anchor ^ (((m_fsa / m_per) % 2) != 0);
    endfunction

    function automatic logic [31:0] m_rd();
        case (address)
            2'd0: return {30'h0, m_ben, m_en};
            2'd1: return {24'h0, m_duty};
            2'd2: return {16'h0, m_per};
            default: return {23'h0, m_phase(), m_pwm()};
        endcase
    endfunction

    initial forever begin
        logic fe, wr, on, gate, ph;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            n = 0; m_en = 1'b1; m_ben = 1'b0; m_duty = 8'hFF; m_act = 8'hFF;
            m_per = '0; m_anchor = 1'b1; m_fsa = 0; m_inq = 8'h00; m_out = pol(8'h00);
        end else begin
            fe   = ((n + 1) % FRAME) == 0;
            wr   = chipselect && !write_n;
            on   = (m_act == 8'hFF) || (m_pwm() < m_act);
            ph   = m_phase();
            gate = m_en && on && (ph || !m_ben);
            m_out = pol(gate ? m_inq : 8'h00);
            m_inq = led_in;
            if (wr && address == 2'd2) begin
                m_anchor = ph; m_fsa = 0;
            end else if (m_per == '0) begin
                m_anchor = 1'b1; m_fsa = 0;
            end else if (fe) begin
                m_fsa++;
            end
            if (fe) m_act = m_duty;
            if (wr) begin
                case (address)
                    2'd0: {m_ben, m_en} = writedata[1:0];
                    2'd1: m_duty = writedata[7:0];
                    2'd2: m_per = writedata[BW-1:0];
                    default: ;
                endcase
            end
            n++;
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        check("led_out", {24'h0, led_out}, {24'h0, m_out});
        check("readdata", readdata, m_rd());
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cyc(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wait_pwm(input logic [7:0] target, input string name);
        address = 2'd3;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (readdata[7:0] == target) break;
            cyc(1);
        end
        check(name, {24'h0, readdata[7:0]}, {24'h0, target});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int on_cnt, off_cnt, len;
        logic [7:0] prev;
        logic [31:0] r, d;
        logic [1:0] a;

        // Reset defaults and two-clock latency
        led_in = 8'hA5;
        cyc(3);
        reset_n = 1'b1;
        cyc(1); check("rst_lat1", {24'h0, led_out}, {24'h0, pol(8'h00)});
        cyc(1); check("rst_lat2", {24'h0, led_out}, {24'h0, pol(8'hA5)});
        address = 2'd0; #1 check("ctrl_def", readdata, 32'h1);
        address = 2'd1; #1 check("duty_def", readdata, 32'hFF);
        address = 2'd2; #1 check("blink_def", readdata, 32'h0);

        // Duty 64/256 over three frames
        led_in = 8'hFF;
        wr(2'd1, 32'd64);
        cyc(FRAME + 4);
        on_cnt = 0; off_cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cyc(1);
            if (led_out == pol(8'hFF)) on_cnt++;
            else if (led_out == pol(8'h00)) off_cnt++;
        end
        check("duty25_on", on_cnt, 3 * 64 * DIV);
        check("duty25_off", off_cnt, 3 * 192 * DIV);

        // Duty shadowing: DUTY=0 written mid-frame with 128 active
        wr(2'd1, 32'd128);
        cyc(FRAME + 4);
        wait_pwm(8'd10, "poll_pwm10");
        wr(2'd1, 32'd0);
        wait_pwm(8'd120, "poll_pwm120");
        check("shadow_still_on", {24'h0, led_out}, {24'h0, pol(8'hFF)});
        wait_pwm(8'd130, "poll_pwm130");
        check("shadow_off", {24'h0, led_out}, {24'h0, pol(8'h00)});
        on_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            cyc(1);
            if (led_out != pol(8'h00)) on_cnt++;
        end
        check("shadow_next_frame_dark", on_cnt, 0);

        // Blink with period 2 frames
        wr(2'd1, 32'hFF);
        wr(2'd0, 32'd3);
        wr(2'd2, 32'd2);
        cyc(FRAME + 4);
        prev = led_out;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cyc(1);
            if (led_out != prev) break;
        end
        for (int k = 0; k < 2; k++) begin
            prev = led_out; len = 0;
            for (int i = 0; i < 4 * FRAME; i++) begin
                cyc(1); len++;
                if (led_out != prev) break;
            end
            check("blink_half_period", len, 2 * FRAME);
        end

        // Disable latency and STATUS write
        wr(2'd0, 32'd1);
        cyc(3);
        check("enabled_on", {24'h0, led_out}, {24'h0, pol(8'hFF)});
        wr(2'd0, 32'd0);
        check("disable_1clk", {24'h0, led_out}, {24'h0, pol(8'hFF)});
        cyc(1);
        check("disable_2clk", {24'h0, led_out}, {24'h0, pol(8'h00)});
        wr(2'd3, 32'hFFFF_FFFF);
        address = 2'd0; #1 check("ctrl_after_st_wr", readdata, 32'h0);
        address = 2'd1; #1 check("duty_after_st_wr", readdata, 32'hFF);
        address = 2'd2; #1 check("blink_after_st_wr", readdata, 32'h2);
        address = 2'd3; #1 check("status_hi_zero", {9'h0, readdata[31:9]}, 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 12000; i++) begin
            led_in  = 8'($urandom);
            address = 2'($urandom);
            r = $urandom;
            if (r[3:0] == 4'h0) begin
                a = 2'($urandom);
                if (a == 2'd2 && r[6:4] != 3'd0) a = 2'd1;
                d = $urandom;
                if (a == 2'd2) d = {d[31:16], 14'h0, d[1:0]};
                chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
            end else begin
                chipselect = r[4];
                write_n    = r[4] ? 1'b1 : r[5];
                writedata  = $urandom;
            end
            cyc(1);
        end
        chipselect = 1'b0; write_n = 1'b1;

        // Asynchronous reset while blink phase is low
        led_in = 8'hFF;
        wr(2'd1, 32'hFF);
        wr(2'd0, 32'd3);
        wr(2'd2, 32'd1);
        cyc(FRAME + 4);
        address = 2'd3;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (readdata[8] == 1'b0) break;
            cyc(1);
        end
        check("phase_low_found", {31'h0, readdata[8]}, 32'h0);
        cyc(2);
        #1 reset_n = 1'b0;
        #1 check("rst_async_led", {24'h0, led_out}, {24'h0, pol(8'h00)});
        check("rst_status", readdata, 32'h100);
        cyc(2);
        reset_n = 1'b1;
        cyc(3);
        check("post_rst_on", {24'h0, led_out}, {24'h0, pol(8'hFF)});
        address = 2'd0; #1 check("post_rst_ctrl", readdata, 32'h1);
        address = 2'd1; #1 check("post_rst_duty", readdata, 32'hFF);
        address = 2'd2; #1 check("post_rst_blink", readdata, 32'h0);
        cyc(1);
        #1 reset_n = 1'b0;
        #1 check("rst_async_no_edge", {24'h0, led_out}, {24'h0, pol(8'h00)});
        cyc(2);
        reset_n = 1'b1;
        cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
- Downstream consumer of the green-LED PIO's 8-bit output.
- Takes the PIO's on/off mask and drives the physical LED pins with software-set brightness (8-bit PWM) and optional blinking.
- Has a small Avalon-MM slave of its own, on the same bus, for control, duty and blink-period registers.
- Sits between the PIO out_port and the board LED pins.

Parameters:
- PRESCALE_DIV, 196, clk cycles per PWM step (≥1). 50 MHz / 196 / 256 ≈ 1 kHz PWM frame.
- BLINK_W, 16, width of the blink-period register, in PWM frames.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- led_in  input  8  LED on/off mask from the PIO out_port
- address  input  2  Avalon register select
- chipselect  input  1  Avalon chip select
- write_n  input  1  Avalon write strobe, active low
- writedata  input  32  Avalon write data
- readdata  output  32  Avalon read data, combinational, zero-extended
- led_out  output  8  LED pin drive, registered

Behaviour:
- Clocking and reset: one clock. reset_n is asynchronous, active-low; all state clears immediately on assertion.
- Register map (write when chipselect && !write_n):
  - addr0 CTRL: bit0 enable, bit1 blink_en. Reset 2'b01.
  - addr1 DUTY: bits[7:0]. Reset 8'hFF.
  - addr2 BLINK_PERIOD: bits[BLINK_W-1:0]. Reset 0.
  - addr3 STATUS: read-only, {23'b0, blink_phase, pwm_cnt}. Writes are ignored.
  - Unused high write bits are ignored; unused read bits return 0.
- Prescaler:
  - Counter 0..PRESCALE_DIV-1; emits a 1-cycle tick at PRESCALE_DIV-1, then returns to 0.
  - PRESCALE_DIV=1 gives a tick every cycle.
- PWM counter:
  - pwm_cnt (8-bit) increments on tick and wraps 255→0.
  - The tick at pwm_cnt==255 is frame_end.
- Duty shadow:
  - DUTY writes go to duty_reg; duty_act loads duty_reg only on frame_end. No mid-frame glitches.
  - Reset value of duty_act is 8'hFF.
  - pwm_on = (duty_act==8'hFF) | (pwm_cnt < duty_act). Duty 0 means always off; 8'hFF means always on.
- Blink:
  - frame_cnt counts frame_end events. When frame_cnt == BLINK_PERIOD-1 on a frame_end: blink_phase toggles and frame_cnt clears.
  - BLINK_PERIOD==0: frame_cnt held 0, blink_phase held 1.
  - A write to BLINK_PERIOD clears frame_cnt in the same cycle.
  - Reset: frame_cnt=0, blink_phase=1.
- Output path:
  - led_in_q <= led_in every cycle; reset 0.
  - led_out <= led_in_q & {8{enable & pwm_on & (blink_phase | ~blink_en)}}; reset 8'h00.
  - Latency led_in→led_out is 2 clk.
  - A CTRL.enable write is visible on led_out 2 clk after the write cycle (1 for the register, 1 for the output flop).
- Simultaneous events:
  - A DUTY write in the same cycle as frame_end: duty_act loads the old duty_reg. The new value applies next frame.
  - A BLINK_PERIOD write in the same cycle as frame_end: the write wins (frame_cnt=0, no toggle).
- Reset mid-frame: all counters and outputs return to reset values asynchronously. Operation restarts from pwm_cnt=0.

Optional Feature:
- Macro: LED_PWM_ACTIVE_LOW_EN.
- Defined: led_out drives the inverted value of the expression above. Reset value 8'hFF (LEDs off on active-low boards). readdata is unaffected.
- Undefined: active-high drive as above, reset 8'h00.

Test Plan:
- Reset defaults: release reset, led_in=8'hA5 → led_out=8'hA5 two clk later. Reads give CTRL=1, DUTY=FF, BLINK=0.
- Duty 25%: PRESCALE_DIV=1, write DUTY=64, led_in=FF → after the next frame_end, led_out=FF for exactly 64 of every 256 cycles. Measured over 3 frames.
- Shadowing: write DUTY=0 at pwm_cnt=10 (old duty 128) → led_out stays FF until pwm_cnt=128 of the current frame, then 00 for the entire next frame.
- Blink: PRESCALE_DIV=1, BLINK_PERIOD=2, CTRL=3, DUTY=FF → led_out toggles FF/00 every 512 cycles. STATUS bit8 tracks the phase.
- Disable and STATUS write: write CTRL=0 → led_out=00 two clk after the write cycle. A write to addr3 leaves STATUS unchanged.
- Async reset mid-blink: assert reset_n low while blink_phase=0 → led_out=00 immediately, without waiting for a clk edge (FF with LED_PWM_ACTIVE_LOW_EN). After release, registers return to defaults.
